// File: rtl/avr_timer_pkg.sv
// Shared address map, channel offsets and decode helper for the avr_timer_multi block.
package avr_timer_pkg;

    localparam logic [4:0] ADDR_TEN   = 5'h00;
    localparam logic [4:0] ADDR_TMODE = 5'h01;
    localparam logic [4:0] ADDR_TIFR  = 5'h02;
    localparam logic [4:0] ADDR_TIMSK = 5'h03;
    localparam logic [4:0] ADDR_PRESC = 5'h1C;

    localparam int CH_BASE      = 4;
    localparam int CH_STRIDE    = 4;
    localparam int MAX_CHANNELS = 6;

    typedef enum logic [1:0] {
        OFF_CNTL  = 2'd0,
        OFF_CNTH  = 2'd1,
        OFF_LOADL = 2'd2,
        OFF_LOADH = 2'd3
    } chan_off_e;

    // True when addr falls inside the four-register window of channel n.
    function automatic logic chan_hit(input logic [4:0] addr, input int n);
        int a;
        a = int'(addr);
        return (a >= CH_BASE + CH_STRIDE * n) && (a < CH_BASE + CH_STRIDE * (n + 1));
    endfunction

endpackage

// File: rtl/avr_timer_chan.sv
// One down-counting reload timer channel: CNT, LOAD, the LOADL staging byte and the CNTH shadow.
module avr_timer_chan
    import avr_timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             enable_i,
    input  logic             mode_i,
    input  logic             wr_loadl_i,
    input  logic             wr_loadh_i,
    input  logic             rd_cntl_i,
    input  logic [7:0]       wdata_i,
    input  logic [WIDTH-9:0] load_hi_i,
    input  chan_off_e        rd_off_i,
    output logic             wrap_o,
    output logic [7:0]       rdata_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] load_new;
    logic [7:0]       ltmp_q, ltmp_d;
    logic [WIDTH-9:0] shadow_q, shadow_d;

    assign load_new = {load_hi_i, ltmp_q};

    // A reload on the same edge as a LOADH commit takes the freshly committed value.
    always_comb begin
        ltmp_d   = wr_loadl_i ? wdata_i : ltmp_q;
        load_d   = wr_loadh_i ? load_new : load_q;
        shadow_d = rd_cntl_i ? cnt_q[WIDTH-1:8] : shadow_q;
        cnt_d    = cnt_q;
        wrap_o   = 1'b0;
        if (!enable_i) begin
            if (wr_loadh_i) begin
                cnt_d = load_new;
            end
        end else if (tick_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else begin
                wrap_o = 1'b1;
                if (!mode_i) begin
                    cnt_d = load_d;
                end
            end
        end
    end

    always_comb begin
        rdata_o = 8'h00;
        case (rd_off_i)
            OFF_CNTL:  rdata_o = cnt_q[7:0];
            OFF_CNTH:  rdata_o = 8'(shadow_q);
            OFF_LOADL: rdata_o = load_q[7:0];
            OFF_LOADH: rdata_o = 8'(load_q[WIDTH-1:8]);
            default:   rdata_o = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            load_q   <= '0;
            ltmp_q   <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            ltmp_q   <= ltmp_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: rtl/avr_timer_multi.sv
// Multi-channel AVR I/O timer: global registers, address decode, read mux and irq.
// Optional shared prescaler at 0x1C is built when AVR_TIMER_PRESCALER_EN is defined.
module avr_timer_multi
    import avr_timer_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 16,
    parameter int PRESC_W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_re,
    input  logic       io_we,
    input  logic [4:0] io_a,
    input  logic [7:0] io_di,
    output logic [7:0] io_do,
    output logic       irq
);

    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS || WIDTH < 9 || WIDTH > 16 || PRESC_W < 1) begin : g_bad_params
        $error("avr_timer_multi: parameter out of range");
    end

    logic                wr_en;
    logic                tick;
    logic [7:0]          presc_rd;
    logic [7:0]          rdata;
    chan_off_e           off;
    logic [CHANNELS-1:0] ten_q, ten_d;
    logic [CHANNELS-1:0] tmode_q, tmode_d;
    logic [CHANNELS-1:0] tifr_q, tifr_d;
    logic [CHANNELS-1:0] timsk_q, timsk_d;
    logic [CHANNELS-1:0] wrap;
    logic                irq_q, irq_d;
    logic [7:0]          chan_rdata [CHANNELS];

    // A cycle carrying both strobes is a read only.
    assign wr_en = io_we & ~io_re;
    assign off   = chan_off_e'(io_a[1:0]);

`ifdef AVR_TIMER_PRESCALER_EN
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic               presc_wr;

    assign presc_wr = wr_en && (io_a == ADDR_PRESC);
    assign tick     = (pcnt_q == presc_q);
    assign presc_rd = 8'(presc_q);

    // Writing PRESC restarts the divider so the new ratio starts cleanly.
    always_comb begin
        presc_d = presc_wr ? PRESC_W'({8'h00, io_di}) : presc_q;
        pcnt_d  = tick ? '0 : pcnt_q + PRESC_W'(1);
        if (presc_wr) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            pcnt_q  <= '0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end
`else
    assign tick     = 1'b1;
    assign presc_rd = 8'h00;
`endif

    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        logic hit;
        assign hit = chan_hit(io_a, n);

        avr_timer_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .tick_i     (tick),
            .enable_i   (ten_q[n]),
            .mode_i     (tmode_q[n]),
            .wr_loadl_i (wr_en & hit & (off == OFF_LOADL)),
            .wr_loadh_i (wr_en & hit & (off == OFF_LOADH)),
            .rd_cntl_i  (io_re & hit & (off == OFF_CNTL)),
            .wdata_i    (io_di),
            .load_hi_i  (io_di[WIDTH-9:0]),
            .rd_off_i   (off),
            .wrap_o     (wrap[n]),
            .rdata_o    (chan_rdata[n])
        );
    end

    // Hardware flag set beats a same-cycle W1C; a one-shot wrap drops its own enable.
    always_comb begin
        ten_d   = ten_q;
        tmode_d = tmode_q;
        tifr_d  = tifr_q;
        timsk_d = timsk_q;
        if (wr_en) begin
            case (io_a)
                ADDR_TEN:   ten_d   = io_di[CHANNELS-1:0];
                ADDR_TMODE: tmode_d = io_di[CHANNELS-1:0];
                ADDR_TIFR:  tifr_d  = tifr_q & ~io_di[CHANNELS-1:0];
                ADDR_TIMSK: timsk_d = io_di[CHANNELS-1:0];
                default:    ;
            endcase
        end
        tifr_d = tifr_d | wrap;
        ten_d  = ten_d & ~(wrap & tmode_q);
        irq_d  = |(tifr_q & timsk_q);
    end

    always_comb begin
        rdata = 8'h00;
        case (io_a)
            ADDR_TEN:   rdata = 8'(ten_q);
            ADDR_TMODE: rdata = 8'(tmode_q);
            ADDR_TIFR:  rdata = 8'(tifr_q);
            ADDR_TIMSK: rdata = 8'(timsk_q);
            ADDR_PRESC: rdata = presc_rd;
            default: begin
                for (int n = 0; n < CHANNELS; n++) begin
                    if (chan_hit(io_a, n)) begin
                        rdata = chan_rdata[n];
                    end
                end
            end
        endcase
    end

    assign io_do = io_re ? rdata : 8'h00;
    assign irq   = irq_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ten_q   <= '0;
            tmode_q <= '0;
            tifr_q  <= '0;
            timsk_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            ten_q   <= ten_d;
            tmode_q <= tmode_d;
            tifr_q  <= tifr_d;
            timsk_q <= timsk_d;
            irq_q   <= irq_d;
        end
    end

endmodule

// File: tb/tb_avr_timer_multi.sv
// Directed self-checking bench for avr_timer_multi with default parameters (2 channels, 16 bits).
module tb_avr_timer_multi;

    localparam logic [4:0] A_TEN   = 5'h00;
    localparam logic [4:0] A_TMODE = 5'h01;
    localparam logic [4:0] A_TIFR  = 5'h02;
    localparam logic [4:0] A_TIMSK = 5'h03;
    localparam logic [4:0] A_C0L   = 5'h04;
    localparam logic [4:0] A_C0H   = 5'h05;
    localparam logic [4:0] A_L0L   = 5'h06;
    localparam logic [4:0] A_L0H   = 5'h07;
    localparam logic [4:0] A_C1L   = 5'h08;
    localparam logic [4:0] A_L1L   = 5'h0A;
    localparam logic [4:0] A_L1H   = 5'h0B;
    localparam logic [4:0] A_PRESC = 5'h1C;
    localparam int         PERIOD  = 10;

    logic       clk;
    logic       rst;
    logic       io_re;
    logic       io_we;
    logic [4:0] io_a;
    logic [7:0] io_di;
    logic [7:0] io_do;
    logic       irq;

    int errors = 0;
    int checks = 0;

    avr_timer_multi dut (
        .clk   (clk),
        .rst   (rst),
        .io_re (io_re),
        .io_we (io_we),
        .io_a  (io_a),
        .io_di (io_di),
        .io_do (io_do),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One-cycle write, called at a negedge and returning at the next one.
    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        io_a  = a;
        io_di = d;
        io_we = 1'b1;
        @(negedge clk);
        io_we = 1'b0;
    endtask

    // One-cycle read whose strobe spans a rising edge (latches SHADOW on CNTL).
    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        io_a  = a;
        io_re = 1'b1;
        #1 d  = io_do;
        @(negedge clk);
        io_re = 1'b0;
    endtask

    // Combinational look without a clock edge in between.
    task automatic peek(input logic [4:0] a, output logic [7:0] d);
        io_a  = a;
        io_re = 1'b1;
        #1 d  = io_do;
        io_re = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        wr(A_L0L, 8'h02);
        wr(A_L0H, 8'h00);
        wr(A_TIMSK, 8'h01);
        wr(A_TEN, 8'h01);
        repeat (6) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_irq: got %b expected 1", irq); end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_irq: got %b expected 0", irq); end
        peek(A_TEN, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_ten: got %h expected 00", d); end
        @(negedge clk);
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            peek(5'(a), d);
            checks++;
            if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_reg_%0h: got %h expected 00", a, d); end
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        @(negedge clk);
    endtask

    task automatic test_periodic;
        logic [7:0] d;
        wr(A_L0L, 8'h03);
        wr(A_L0H, 8'h00);
        wr(A_TIMSK, 8'h01);
        wr(A_TEN, 8'h01);
        repeat (3) @(negedge clk);
        peek(A_TIFR, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL per_flag_early: got %h expected 00", d); end
        @(negedge clk);
        peek(A_TIFR, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL per_flag_set: got %h expected 01", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL per_irq_lag: got %b expected 0", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("[TB] FAIL per_irq_rise: got %b expected 1", irq); end
        wr(A_TIFR, 8'h01);
        peek(A_TIFR, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL per_w1c: got %h expected 00", d); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("[TB] FAIL per_irq_hold: got %b expected 1", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL per_irq_clear: got %b expected 0", irq); end
        @(negedge clk);
        peek(A_TIFR, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL per_flag_again: got %h expected 01", d); end
        peek(A_C0L, d);
        checks++;
        if (d !== 8'h03) begin errors++; $display("[TB] FAIL per_reload: got %h expected 03", d); end
        wr(A_TEN, 8'h00);
        wr(A_TIFR, 8'h01);
        wr(A_TIMSK, 8'h00);
    endtask

    task automatic test_set_clear;
        logic [7:0] d;
        wr(A_L0L, 8'h03);
        wr(A_L0H, 8'h00);
        wr(A_TEN, 8'h01);
        repeat (3) @(negedge clk);
        wr(A_TIFR, 8'h01);
        peek(A_TIFR, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL set_beats_clear: got %h expected 01", d); end
        wr(A_TIFR, 8'h01);
        peek(A_TIFR, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL plain_clear: got %h expected 00", d); end
        wr(A_TEN, 8'h00);
        wr(A_TIFR, 8'h01);
    endtask

    task automatic test_oneshot;
        logic [7:0] d;
        wr(A_L1L, 8'h05);
        wr(A_L1H, 8'h01);
        wr(A_TMODE, 8'h02);
        wr(A_TEN, 8'h02);
        repeat (261) @(negedge clk);
        peek(A_TIFR, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL os_flag_early: got %h expected 00", d); end
        peek(A_TEN, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("[TB] FAIL os_ten_running: got %h expected 02", d); end
        @(negedge clk);
        peek(A_TIFR, d);
        checks++;
        if (d !== 8'h02) begin errors++; $display("[TB] FAIL os_flag_set: got %h expected 02", d); end
        peek(A_TEN, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL os_ten_cleared: got %h expected 00", d); end
        peek(A_C1L, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL os_cnt_zero: got %h expected 00", d); end
        repeat (4) @(negedge clk);
        peek(A_C1L, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL os_cnt_hold: got %h expected 00", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("[TB] FAIL os_irq_masked: got %b expected 0", irq); end
        wr(A_TIFR, 8'h02);
        wr(A_TMODE, 8'h00);
    endtask

    task automatic test_atomic;
        logic [7:0] d;
        wr(A_L0L, 8'h00);
        wr(A_L0H, 8'h01);
        wr(A_TEN, 8'h01);
        rd(A_C0L, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL atomic_cntl: got %h expected 00", d); end
        @(negedge clk);
        peek(A_C0L, d);
        checks++;
        if (d !== 8'hFE) begin errors++; $display("[TB] FAIL atomic_cnt_moved: got %h expected fe", d); end
        rd(A_C0H, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL atomic_cnth: got %h expected 01", d); end
        wr(A_L0L, 8'h34);
        peek(A_L0L, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL loadl_staged_lo: got %h expected 00", d); end
        peek(A_L0H, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL loadl_staged_hi: got %h expected 01", d); end
        wr(A_L0H, 8'h12);
        peek(A_L0L, d);
        checks++;
        if (d !== 8'h34) begin errors++; $display("[TB] FAIL loadh_commit_lo: got %h expected 34", d); end
        peek(A_L0H, d);
        checks++;
        if (d !== 8'h12) begin errors++; $display("[TB] FAIL loadh_commit_hi: got %h expected 12", d); end
        rd(A_C0L, d);
        rd(A_C0H, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL running_no_cnt_load: got %h expected 00", d); end
        wr(A_TEN, 8'h00);
        wr(A_L0H, 8'h12);
        repeat (5) @(negedge clk);
        peek(A_C0L, d);
        checks++;
        if (d !== 8'h34) begin errors++; $display("[TB] FAIL idle_cnt_load_lo: got %h expected 34", d); end
        rd(A_C0L, d);
        rd(A_C0H, d);
        checks++;
        if (d !== 8'h12) begin errors++; $display("[TB] FAIL idle_cnt_load_hi: got %h expected 12", d); end
    endtask

    task automatic test_bus_edges;
        logic [7:0] d;
        wr(A_TIMSK, 8'hFF);
        peek(A_TIMSK, d);
        checks++;
        if (d !== 8'h03) begin errors++; $display("[TB] FAIL upper_bits_masked: got %h expected 03", d); end
        io_a = A_TIMSK;
        #1;
        checks++;
        if (io_do !== 8'h00) begin errors++; $display("[TB] FAIL io_do_idle: got %h expected 00", io_do); end
        io_di = 8'h00;
        io_re = 1'b1;
        io_we = 1'b1;
        #1 d  = io_do;
        checks++;
        if (d !== 8'h03) begin errors++; $display("[TB] FAIL rw_read_data: got %h expected 03", d); end
        @(negedge clk);
        io_re = 1'b0;
        io_we = 1'b0;
        peek(A_TIMSK, d);
        checks++;
        if (d !== 8'h03) begin errors++; $display("[TB] FAIL rw_no_write: got %h expected 03", d); end
        wr(5'h0E, 8'hFF);
        wr(5'h1D, 8'hFF);
        peek(5'h0E, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL absent_chan: got %h expected 00", d); end
        peek(5'h1D, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL unmapped: got %h expected 00", d); end
        wr(A_TIMSK, 8'h00);
    endtask

    task automatic test_prescaler;
        logic [7:0] d;
        longint     t0;
        longint     t1;
        int         found;
        logic [7:0] presc_exp;
        int         period_exp;
`ifdef AVR_TIMER_PRESCALER_EN
        presc_exp  = 8'h02;
        period_exp = 6;
`else
        presc_exp  = 8'h00;
        period_exp = 2;
`endif
        t0 = 0;
        t1 = 0;
        found = 0;
        wr(A_L0L, 8'h01);
        wr(A_L0H, 8'h00);
        wr(A_TIFR, 8'h03);
        wr(A_PRESC, 8'h02);
        peek(A_PRESC, d);
        checks++;
        if (d !== presc_exp) begin errors++; $display("[TB] FAIL presc_reg: got %h expected %h", d, presc_exp); end
        wr(A_TEN, 8'h01);
        for (int i = 0; i < 40 && found < 2; i++) begin
            peek(A_TIFR, d);
            if (d[0]) begin
                if (found == 0) t0 = $time;
                else            t1 = $time;
                found++;
                if (found < 2) wr(A_TIFR, 8'h01);
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (found !== 2) begin errors++; $display("[TB] FAIL presc_flags_seen: got %0d expected 2", found); end
        checks++;
        if ((t1 - t0) !== longint'(period_exp * PERIOD)) begin
            errors++;
            $display("[TB] FAIL presc_period: got %0d expected %0d", t1 - t0, period_exp * PERIOD);
        end
        wr(A_TEN, 8'h00);
    endtask

    initial begin
        rst   = 1'b0;
        io_re = 1'b0;
        io_we = 1'b0;
        io_a  = 5'h00;
        io_di = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_periodic();
        test_set_clear();
        test_oneshot();
        test_atomic();
        test_bus_edges();
        test_prescaler();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
